// File: rtl/data_channel_ctrl_pkg.sv
// Shared definitions for the data-channel frame sequencer: pixel-format codes,
// FSM state encoding and the supported-format check.
package data_channel_ctrl_pkg;

  localparam logic [31:0] FmtMono8    = 32'h0108_0001;
  localparam logic [31:0] FmtMono10   = 32'h0110_0003;
  localparam logic [31:0] FmtBayGr8   = 32'h0108_0008;
  localparam logic [31:0] FmtBayGr10  = 32'h0110_000C;
  localparam logic [31:0] FmtDefault  = FmtMono8;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StArmed,
    StSkip,
    StFrame
  } state_e;

  function automatic logic fmt_supported(input logic [31:0] fmt);
    return (fmt == FmtMono8) || (fmt == FmtMono10) || (fmt == FmtBayGr8) || (fmt == FmtBayGr10);
  endfunction

endpackage

// File: rtl/data_channel_ctrl.sv
// Frame-level gate in front of the data_align packer: passes only whole frames while
// streaming is enabled, shadows the pixel format between frames and counts passed frames.
module data_channel_ctrl
  import data_channel_ctrl_pkg::*;
#(
  parameter int unsigned SENSOR_DAT_WIDTH = 10,
  parameter int unsigned REG_WD           = 32,
  parameter int unsigned FRAME_CNT_WD     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_stream_enable,
  input  logic                        i_acquisition_start,
  input  logic [REG_WD-1:0]           iv_pixel_format,
  input  logic                        i_fval,
  input  logic                        i_lval,
  input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
  output logic                        o_fval,
  output logic                        o_lval,
  output logic [SENSOR_DAT_WIDTH-1:0] ov_pix_data,
  output logic [REG_WD-1:0]           ov_pixel_format,
  output logic                        o_frame_active,
  output logic                        o_format_err,
  output logic [FRAME_CNT_WD-1:0]     ov_frame_cnt
);

  state_e                        state_q;
  logic                          fval_q, lval_q, err_q;
  logic [SENSOR_DAT_WIDTH-1:0]   pix_q;
  logic [REG_WD-1:0]             fmt_q;
  logic [FRAME_CNT_WD-1:0]       cnt_q;

  logic en, fmt_ok, start, pass;

  assign en     = i_stream_enable & i_acquisition_start;
  assign fmt_ok = fmt_supported(32'(iv_pixel_format));
  assign start  = (state_q == StArmed) & en & i_fval & fmt_ok;
  assign pass   = start | ((state_q == StFrame) & i_fval);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      pix_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      fmt_q   <= REG_WD'(FmtDefault);
    end else begin
      fval_q <= pass;
      lval_q <= pass & i_lval;
      pix_q  <= (pass & i_lval) ? iv_pix_data : '0;
      err_q  <= 1'b0;
      // Shadow is frozen from the first gated fval cycle until the frame ends.
      if ((state_q != StFrame) && !start) begin
        fmt_q <= iv_pixel_format;
      end
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StWait;
        end
        StWait: begin
          if (!en)          state_q <= StIdle;
          else if (!i_fval) state_q <= StArmed;
        end
        StArmed: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (i_fval) begin
            if (fmt_ok) begin
              state_q <= StFrame;
            end else begin
              state_q <= StSkip;
              err_q   <= 1'b1;
            end
          end
        end
        StSkip: begin
          if (!i_fval) state_q <= en ? StArmed : StIdle;
        end
        StFrame: begin
          // Dropping en mid-frame never truncates; it only decides where we land afterwards.
          if (!i_fval) begin
            state_q <= en ? StArmed : StIdle;
            cnt_q   <= cnt_q + FRAME_CNT_WD'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_fval          = fval_q;
  assign o_lval          = lval_q;
  assign ov_pix_data     = pix_q;
  assign ov_pixel_format = fmt_q;
  assign o_format_err    = err_q;
  assign ov_frame_cnt    = cnt_q;
  assign o_frame_active  = (state_q == StFrame);

endmodule

// File: tb/tb_data_channel_ctrl.sv
// Scoreboard bench for data_channel_ctrl: a frame-level reference model predicts every
// output cycle, a separate monitor pops and compares.
module tb_data_channel_ctrl;

  localparam int DW = 10;
  localparam int RW = 32;
  localparam int CW = 8;

  localparam logic [31:0] MONO8  = 32'h0108_0001;
  localparam logic [31:0] MONO10 = 32'h0110_0003;
  localparam logic [31:0] BGR8   = 32'h0108_0008;
  localparam logic [31:0] BGR10  = 32'h0110_000C;
  localparam logic [31:0] BADFMT = 32'h0108_0002;

  logic          clk, rst_n;
  logic          i_stream_enable, i_acquisition_start;
  logic [RW-1:0] iv_pixel_format;
  logic          i_fval, i_lval;
  logic [DW-1:0] iv_pix_data;
  logic          o_fval, o_lval, o_frame_active, o_format_err;
  logic [DW-1:0] ov_pix_data;
  logic [RW-1:0] ov_pixel_format;
  logic [CW-1:0] ov_frame_cnt;

  data_channel_ctrl #(
    .SENSOR_DAT_WIDTH(DW),
    .REG_WD          (RW),
    .FRAME_CNT_WD    (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_stream_enable    (i_stream_enable),
    .i_acquisition_start(i_acquisition_start),
    .iv_pixel_format    (iv_pixel_format),
    .i_fval             (i_fval),
    .i_lval             (i_lval),
    .iv_pix_data        (iv_pix_data),
    .o_fval             (o_fval),
    .o_lval             (o_lval),
    .ov_pix_data        (ov_pix_data),
    .ov_pixel_format    (ov_pixel_format),
    .o_frame_active     (o_frame_active),
    .o_format_err       (o_format_err),
    .ov_frame_cnt       (ov_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          fval;
    logic          lval;
    logic [DW-1:0] pix;
    logic [RW-1:0] fmt;
    logic          act;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: frame-level flags rather than a state register.
  bit            m_woke, m_armed, m_passing, m_skipping;
  logic [CW-1:0] m_cnt;
  logic [RW-1:0] m_shadow;

  function automatic bit supported(input logic [31:0] f);
    return f == MONO8 || f == MONO10 || f == BGR8 || f == BGR10;
  endfunction

  task automatic model_reset();
    m_woke = 0; m_armed = 0; m_passing = 0; m_skipping = 0;
    m_cnt = '0;
    m_shadow = MONO8;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit   en, pass, err, was_passing, started;
    exp_t e;
    en = i_stream_enable & i_acquisition_start;
    pass = 0; err = 0; started = 0;
    was_passing = m_passing;
    if (m_passing) begin
      pass = i_fval;
      if (!i_fval) begin
        m_passing = 0; m_cnt = m_cnt + 1'b1; m_woke = en; m_armed = en;
      end
    end else if (m_skipping) begin
      if (!i_fval) begin
        m_skipping = 0; m_woke = en; m_armed = en;
      end
    end else if (!en) begin
      m_woke = 0; m_armed = 0;
    end else if (!m_woke) begin
      m_woke = 1;
    end else if (!m_armed) begin
      if (!i_fval) m_armed = 1;
    end else if (i_fval) begin
      m_armed = 0;
      if (supported(iv_pixel_format)) begin
        m_passing = 1; started = 1; pass = 1;
      end else begin
        m_skipping = 1; err = 1;
      end
    end
    if (!was_passing && !started) m_shadow = iv_pixel_format;
    e.fval = pass;
    e.lval = pass & i_lval;
    e.pix  = e.lval ? iv_pix_data : '0;
    e.fmt  = m_shadow;
    e.act  = m_passing;
    e.err  = err;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_fval", 64'(o_fval), 64'(0));
        chk("rst_lval", 64'(o_lval), 64'(0));
        chk("rst_pix", 64'(ov_pix_data), 64'(0));
        chk("rst_err", 64'(o_format_err), 64'(0));
        chk("rst_cnt", 64'(ov_frame_cnt), 64'(0));
        chk("rst_fmt", 64'(ov_pixel_format), 64'(MONO8));
        chk("rst_active", 64'(o_frame_active), 64'(0));
      end else if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("fval", 64'(o_fval), 64'(e.fval));
        chk("lval", 64'(o_lval), 64'(e.lval));
        chk("pix", 64'(ov_pix_data), 64'(e.pix));
        chk("fmt", 64'(ov_pixel_format), 64'(e.fmt));
        chk("active", 64'(o_frame_active), 64'(e.act));
        chk("fmt_err", 64'(o_format_err), 64'(e.err));
        chk("cnt", 64'(ov_frame_cnt), 64'(e.cnt));
      end
    end
  end

  // Stimulus: register-side values are staged in *_next and applied with each drive.
  bit            en_next, acq_next;
  logic [RW-1:0] fmt_next;

  task automatic drive(input bit f, input bit l, input logic [DW-1:0] d);
    @(negedge clk);
    i_stream_enable     = en_next;
    i_acquisition_start = acq_next;
    iv_pixel_format     = fmt_next;
    i_fval              = f;
    i_lval              = l;
    iv_pix_data         = d;
  endtask

  // drop_line: 0 drops en on the rising-fval cycle, k>0 at the start of line k, -1 never.
  task automatic frame(input int lines, input int len, input int drop_line,
                       input bit chg, input logic [RW-1:0] mid_fmt, input bit rnd);
    logic [DW-1:0] d;
    if (drop_line == 0) en_next = 0;
    drive(1, 0, DW'($urandom));
    for (int ln = 1; ln <= lines; ln++) begin
      if (ln == drop_line) en_next = 0;
      if (chg && ln == 2) fmt_next = mid_fmt;
      for (int p = 0; p < len; p++) begin
        d = rnd ? DW'($urandom) : (p[0] ? DW'(10'h001) : DW'(10'h3FF));
        drive(1, 1, d);
        if (rnd ? ($urandom_range(0, 3) == 0) : (p == 1)) drive(1, 0, DW'($urandom));
      end
      drive(1, 0, DW'($urandom));
    end
    // lval toggling while fval is low must be ignored.
    repeat (3) drive(0, 1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  function automatic logic [RW-1:0] rand_fmt();
    case ($urandom_range(0, 5))
      0: return MONO8;
      1: return MONO10;
      2: return BGR8;
      3: return BGR10;
      4: return BADFMT;
      default: return RW'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 0;
    en_next = 0; acq_next = 1; fmt_next = MONO8;
    i_stream_enable = 0; i_acquisition_start = 1; iv_pixel_format = MONO8;
    i_fval = 0; i_lval = 0; iv_pix_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) drive(0, 0, '0);

    // Enable while the sensor is already mid-frame; the following frame passes whole.
    drive(1, 1, 10'h155);
    drive(1, 1, 10'h0AA);
    en_next = 1;
    repeat (6) drive(1, 1, DW'($urandom));
    repeat (3) drive(0, 0, '0);
    frame(3, 4, -1, 0, '0, 1);

    // Format change mid-frame is held off until the frame ends.
    fmt_next = MONO10;
    repeat (2) drive(0, 0, '0);
    frame(4, 3, -1, 1, MONO8, 1);
    frame(2, 3, -1, 0, '0, 1);

    // Unsupported format drops the frame; the next valid one passes.
    fmt_next = BADFMT;
    repeat (2) drive(0, 0, '0);
    frame(3, 3, -1, 0, '0, 1);
    fmt_next = MONO8;
    frame(3, 3, -1, 0, '0, 1);

    // en dropped at line 3 of 8: frame completes, next frame blocked, then re-enable.
    frame(8, 3, 3, 0, '0, 1);
    frame(2, 3, -1, 0, '0, 1);
    en_next = 1;
    repeat (3) drive(0, 0, '0);
    frame(2, 3, -1, 0, '0, 1);

    // en drop on the same cycle as the rising fval while armed.
    frame(2, 3, 0, 0, '0, 1);
    en_next = 1;
    repeat (3) drive(0, 0, '0);

    // 0x3FF/0x001 pattern with lval gaps.
    frame(3, 6, -1, 0, '0, 0);

    // Reset mid-frame, then resynchronise through the wait-for-fval-low path.
    drive(1, 0, '0);
    repeat (3) drive(1, 1, DW'($urandom));
    @(negedge clk);
    rst_n = 0;
    repeat (2) drive(1, 1, DW'($urandom));
    rst_n = 1;
    repeat (4) drive(1, 1, DW'($urandom));
    repeat (3) drive(0, 0, '0);
    frame(2, 3, -1, 0, '0, 1);

    // Enough short frames to wrap the counter.
    for (int i = 0; i < 260; i++) frame(1, 1, -1, 0, '0, 1);

    // Randomised mix of formats, enables and mid-frame changes.
    for (int i = 0; i < 60; i++) begin
      en_next  = ($urandom_range(0, 4) != 0);
      acq_next = ($urandom_range(0, 6) != 0);
      fmt_next = rand_fmt();
      repeat ($urandom_range(0, 3)) drive(0, 0, DW'($urandom));
      frame($urandom_range(1, 5), $urandom_range(1, 8),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
            1'($urandom_range(0, 1)), rand_fmt(), 1);
    end

    repeat (4) drive(0, 0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
